// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between a memory stage and the data memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_ready;
    modport master (output req_valid, req_write, req_addr, req_wdata, rsp_ready,
                    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
                    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data memory with fixed response latency.
// Define DATA_MEM_RESPONDER_ERR_EN to flag and suppress accesses at addresses >= DEPTH.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic clk,
    input logic rst_n,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q, err_q;
    logic [AW-1:0]   idx_q;
    logic [15:0]     wdata_q, rdata_q;
    logic [15:0]     mem [DEPTH];
    logic            accept, enter, err_a, wr_e, err_e;
    logic [AW-1:0]   idx_e;
    logic [15:0]     wdata_e;
`ifdef DATA_MEM_RESPONDER_ERR_EN
    assign err_a = bus.req_addr >= 16'(DEPTH);
`else
    assign err_a = 1'b0;
`endif
    assign accept  = state_q == IDLE && bus.req_valid;
    // With LATENCY=1 the access happens on the accepting edge, so use the live request.
    assign wr_e    = state_q == IDLE ? bus.req_write            : write_q;
    assign idx_e   = state_q == IDLE ? bus.req_addr[AW-1:0]     : idx_q;
    assign wdata_e = state_q == IDLE ? bus.req_wdata            : wdata_q;
    assign err_e   = state_q == IDLE ? err_a                    : err_q;
    assign enter   = (accept && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = LATENCY == 1 ? RESP : WAIT;
                cnt_d   = 4'(LATENCY - 1);
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? RESP : WAIT;
            end
            RESP: state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= bus.req_write;
                err_q   <= err_a;
                idx_q   <= bus.req_addr[AW-1:0];
                wdata_q <= bus.req_wdata;
            end
            if (enter) rdata_q <= (wr_e || err_e) ? 16'h0 : mem[idx_e];
        end
    end
    // Storage is deliberately not reset; rst_n gating keeps an aborted store from landing.
    always_ff @(posedge clk) begin
        if (rst_n && enter && wr_e && !err_e) mem[idx_e] <= wdata_e;
    end
    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_write = state_q == RESP && write_q;
    assign bus.rsp_rdata = state_q == RESP ? rdata_q : 16'h0;
    assign bus.rsp_err   = state_q == RESP && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the data memory responder (LATENCY=2 and LATENCY=1 instances).
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    data_mem_responder_if b();
    data_mem_responder_if b1();
    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!b.rsp_valid && lat < 20);
    endtask
    task automatic finish_rsp();
        b.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b.rsp_ready = 1'b0;
        @(negedge clk);
        check("ready_after_rsp", b.req_ready, 1'b1);
    endtask
    // Issue one request from a negedge, scramble req_* after acceptance, return the response.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output logic rw, output logic re, output int lat);
        check("req_ready_idle", b.req_ready, 1'b1);
        b.req_valid = 1'b1; b.req_write = w; b.req_addr = a; b.req_wdata = d;
        @(posedge clk);
        #1 b.req_valid = 1'b0; b.req_write = ~w; b.req_addr = 16'hFFFF; b.req_wdata = 16'h0;
        wait_rsp(lat);
        rd = b.rsp_rdata; rw = b.rsp_write; re = b.rsp_err;
        finish_rsp();
    endtask
    initial begin
        logic [15:0] rd;
        logic rw, re;
        int lat;
        b.req_valid = 0; b.req_write = 0; b.req_addr = 0; b.req_wdata = 0; b.rsp_ready = 0;
        b1.req_valid = 0; b1.req_write = 0; b1.req_addr = 0; b1.req_wdata = 0; b1.rsp_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", b.req_ready, 1'b1);
        check("rst_rsp_valid", b.rsp_valid, 1'b0);
        check("rst_rsp_write", b.rsp_write, 1'b0);
        check("rst_rsp_rdata", b.rsp_rdata, 16'h0);
        check("rst_rsp_err", b.rsp_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1'b1, 16'h0005, 16'hBEEF, rd, rw, re, lat);
        check("st5_lat", lat, 2);
        check("st5_write", rw, 1'b1);
        check("st5_rdata", rd, 16'h0);
        check("st5_err", re, 1'b0);
        do_req(1'b0, 16'h0005, 16'h0, rd, rw, re, lat);
        check("ld5_lat", lat, 2);
        check("ld5_write", rw, 1'b0);
        check("ld5_rdata", rd, 16'hBEEF);
        // Backpressure: new request waits while the response is held.
        b.req_valid = 1'b1; b.req_write = 1'b0; b.req_addr = 16'h0005;
        @(posedge clk);
        #1 b.req_write = 1'b1; b.req_addr = 16'h0009; b.req_wdata = 16'h5555;
        wait_rsp(lat);
        check("bp_lat", lat, 2);
        repeat (5) begin
            check("bp_valid", b.rsp_valid, 1'b1);
            check("bp_rdata", b.rsp_rdata, 16'hBEEF);
            check("bp_write", b.rsp_write, 1'b0);
            check("bp_req_ready", b.req_ready, 1'b0);
            @(negedge clk);
        end
        b.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b.rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_ready", b.req_ready, 1'b1);
        check("bp_idle_valid", b.rsp_valid, 1'b0);
        @(posedge clk);
        #1 b.req_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", b.req_ready, 1'b0);
        wait_rsp(lat);
        check("bp_st_lat", lat, 1);
        check("bp_st_write", b.rsp_write, 1'b1);
        finish_rsp();
        do_req(1'b0, 16'h0009, 16'h0, rd, rw, re, lat);
        check("ld9_rdata", rd, 16'h5555);
        // Reset during WAIT aborts the pending store.
        do_req(1'b1, 16'h0007, 16'h1111, rd, rw, re, lat);
        b.req_valid = 1'b1; b.req_write = 1'b1; b.req_addr = 16'h0007; b.req_wdata = 16'h1234;
        @(posedge clk);
        #1 b.req_valid = 1'b0;
        @(negedge clk);
        check("wait_state", b.req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", b.req_ready, 1'b1);
        check("arst_rsp_valid", b.rsp_valid, 1'b0);
        check("arst_rsp_rdata", b.rsp_rdata, 16'h0);
        @(negedge clk);
        check("arst_hold_valid", b.rsp_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1'b0, 16'h0007, 16'h0, rd, rw, re, lat);
        check("ld7_after_abort", rd, 16'h1111);
        // Out-of-range address behaviour.
        do_req(1'b1, 16'h0003, 16'h3333, rd, rw, re, lat);
        do_req(1'b1, 16'h0103, 16'hAAAA, rd, rw, re, lat);
`ifdef DATA_MEM_RESPONDER_ERR_EN
        check("oor_err", re, 1'b1);
        do_req(1'b0, 16'h0003, 16'h0, rd, rw, re, lat);
        check("oor_ld3", rd, 16'h3333);
`else
        check("oor_err", re, 1'b0);
        do_req(1'b0, 16'h0003, 16'h0, rd, rw, re, lat);
        check("oor_ld3", rd, 16'hAAAA);
`endif
        // LATENCY=1: back-to-back requests accepted every other cycle.
        b1.req_write = 1'b1; b1.req_addr = 16'h0002; b1.req_wdata = 16'h0007;
        b1.rsp_ready = 1'b1; b1.req_valid = 1'b1;
        check("l1_idle_ready", b1.req_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("l1_rsp_valid", b1.rsp_valid, (i % 2) == 0);
            check("l1_req_ready", b1.req_ready, (i % 2) == 1);
        end
        b1.req_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, words of storage (power of two, 2..4096).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response valid (1..15).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  memory-stage request present.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  16  word address.
REQ-008 req_wdata  input  16  store data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_write  output  1  echo of the accepted req_write.
REQ-012 rsp_rdata  output  16  load data; 0 for stores.
REQ-013 rsp_err  output  1  out-of-range access flag.
REQ-014 rsp_ready  input  1  memory stage accepts the response.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
REQ-017 On acceptance, req_write, req_addr and req_wdata SHALL be captured; later changes on req_* have no effect.
REQ-018 On acceptance, the FSM SHALL go to RESP if LATENCY=1, else to WAIT with a counter loaded to LATENCY-1.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 1.
REQ-020 rsp_valid SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-021 The store SHALL commit to storage on the same edge rsp_valid rises; a load SHALL sample storage on that edge.
REQ-022 In RESP, rsp_valid, rsp_write, rsp_rdata and rsp_err SHALL remain stable until rsp_valid && rsp_ready.
REQ-023 On rsp_valid && rsp_ready, the FSM SHALL return to IDLE; req_ready SHALL be 1 on the following cycle.
REQ-024 Only one request SHALL be outstanding; minimum spacing between acceptances is LATENCY+1 cycles.
REQ-025 A load following a store to the same address SHALL return the stored value.
REQ-026 In IDLE and WAIT, rsp_valid, rsp_write, rsp_err SHALL be 0 and rsp_rdata SHALL be 0.
REQ-027 The storage index SHALL be req_addr[log2(DEPTH)-1:0].

Reset
REQ-028 While rst_n=0: FSM=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0.
REQ-029 Reset asserted in WAIT SHALL abort the operation; a pending store SHALL NOT commit.
REQ-030 Storage contents SHALL NOT be cleared by reset; unwritten locations read as undefined.

Configuration
REQ-031 Macro DATA_MEM_RESPONDER_ERR_EN defined: an address >= DEPTH SHALL set rsp_err=1, suppress the store, and return rsp_rdata=0.
REQ-032 Macro undefined: addresses SHALL wrap modulo DEPTH per REQ-027, and rsp_err SHALL be tied to 0.

Verification
REQ-033 Reset, then store 0xBEEF to address 0x0005 (LATENCY=2) -> rsp_valid rises 2 cycles after acceptance with rsp_write=1, rsp_rdata=0x0000, rsp_err=0.
REQ-034 Load 0x0005 after REQ-033 -> rsp_rdata=0xBEEF, rsp_write=0 at acceptance+2.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP while req_valid=1 with a new request -> outputs stable, req_ready=0, no acceptance until one cycle after rsp_ready=1.
REQ-036 Store 0x1234 to 0x0007, assert rst_n=0 in WAIT, release, load 0x0007 -> the load does not return 0x1234 unless that value was previously stored there; all outputs read 0 during reset.
REQ-037 DEPTH=256: store 0xAAAA to 0x0103 -> with ERR_EN: rsp_err=1, a later load of 0x0003 does not return 0xAAAA; without ERR_EN: rsp_err=0, a later load of 0x0003 returns 0xAAAA.
REQ-038 LATENCY=1, back-to-back req_valid with rsp_ready=1 -> acceptances every 2 cycles, rsp_valid one cycle after each acceptance.
